state_byte_assembler: RTL and testbench
=======================================

Name: state_byte_assembler

Overview:
- Byte-serial to flat converter for the AES datapath.
- Collects 16 state bytes from a valid/ready byte stream and packs them into the 128-bit flat state word used between the round stages.
- Byte k (k = row + 4*col) lands in bits [8k+7:8k], so element [0][0] is in [7:0] and element [3][3] is in [127:120].
- Double-buffered: the next block can fill while the previous assembled word waits for the consumer.

Parameters:
- NUM_BYTES, 16, bytes per block; output width is 8*NUM_BYTES.
- MSB_FIRST, 0, byte order. 0: first received byte goes to [7:0]. 1: first received byte goes to [8*NUM_BYTES-1 : 8*NUM_BYTES-8].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous abort; drops the partial block and the held output.
- in_byte  in  8  input byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  assembler accepts a byte this cycle.
- out_state  out  8*NUM_BYTES  assembled flat state.
- out_valid  out  1  out_state holds a complete block.
- out_ready  in  1  consumer takes out_state.
- byte_cnt  out  $clog2(NUM_BYTES)  bytes held in the partial block.

Behaviour:
- Reset (rst=1, async): state=FILL, byte_cnt=0, out_valid=0, out_state=0, assembly register=0, in_ready=1 once rst is deasserted.
- Input accept: in_valid & in_ready at a clock edge. Output transfer: out_valid & out_ready at a clock edge.
- Byte placement: the accepted byte is written into slot byte_cnt, or slot NUM_BYTES-1-byte_cnt when MSB_FIRST=1. Other slots are unchanged. byte_cnt increments.
- State FILL: in_ready=1.
- Last-byte accept in FILL (byte_cnt==NUM_BYTES-1):
  - If !out_valid or out_ready in that cycle: out_state <= assembled word including this byte; out_valid=1 from the next cycle; byte_cnt=0; remain in FILL.
  - Otherwise: byte goes into the assembly register; byte_cnt=0; go to STALL.
- State STALL: in_ready=0. On an output transfer, out_state <= assembly register, out_valid stays 1, go to FILL.
- Output transfer with no reload on the same edge: out_valid=0 next cycle. out_state holds its value; it is don't-care while out_valid=0.
- Latency: out_valid rises on the edge that accepts the last byte. The block is visible the following cycle, one cycle after the final input handshake.
- Throughput: 1 byte/clk sustained while out_ready=1. No bubble between blocks.
- out_state is stable while out_valid=1 and out_ready=0.
- Simultaneous events: output transfer plus last-byte accept on the same edge means reload, with out_valid staying 1. Output transfer plus non-last byte accept means both occur independently.
- clr=1 (priority over handshakes, below rst): byte_cnt=0, out_valid=0, state=FILL, assembly register cleared. Input and output handshakes in that cycle are ignored (no state update).
- The assembly register is not cleared between blocks; every slot is overwritten before use.
- byte_cnt wraps NUM_BYTES-1 to 0 only on last-byte accept. It never exceeds NUM_BYTES-1.
- rst asserted mid-block: all state drops immediately; no partial block is ever emitted.

Optional Feature:
- Macro: STATE_PARITY_EN (concurrent error detection on the byte link).
- Defined:
  - Adds in_par (in, 1), the even parity of in_byte.
  - Adds out_par_err (out, 1).
  - Each accepted byte is checked as ^{in_byte,in_par}; a result of 1 is a mismatch.
  - A mismatch sets a sticky per-block error bit, which travels with the block through STALL and the output register.
  - out_par_err equals that bit whenever out_valid=1, and is 0 otherwise.
  - The per-block error bit clears at block start, on clr, and on rst.
- Undefined: in_par and out_par_err are absent; no parity logic.

Test Plan:
- Reset, MSB_FIRST=0, out_ready=1, bytes 0x00..0x0F on consecutive cycles → out_valid for 1 cycle the cycle after byte 0x0F; out_state=0x0F0E0D0C0B0A09080706050403020100.
- MSB_FIRST=1, same bytes → out_state=0x000102030405060708090A0B0C0D0E0F.
- out_ready=0: send block A (0x00..0x0F) then block B (0x10..0x1F).
  - in_ready drops after B's 16th byte; out_state=A is held.
  - Raise out_ready for 1 cycle → out_state=0x1F1E...10 next cycle, in_ready=1.
- 7 bytes sent, then clr pulse → byte_cnt=0, out_valid=0. The next 16 bytes 0xA0..0xAF form 0xAFAE...A0 with no residue.
- rst asserted async mid-block (byte_cnt=9) while out_valid=1 → out_valid, byte_cnt and out_state go to 0 without a clock edge.
- STATE_PARITY_EN: block with byte 5 given a wrong in_par → out_par_err=1 with that block. The next clean block gives out_par_err=0.

Source files
------------

// File: rtl/state_byte_assembler_if.sv
// Byte-stream in / flat AES state out link for state_byte_assembler.
// STATE_PARITY_EN adds the in_par / out_par_err pair.
interface state_byte_assembler_if #(
  parameter int NUM_BYTES = 16
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic          clr;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_state;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] byte_cnt;
`ifdef STATE_PARITY_EN
  logic          in_par;
  logic          out_par_err;
`endif

  modport master (
    output clr,
    output in_byte,
    output in_valid,
    input  in_ready,
    input  out_state,
    input  out_valid,
    output out_ready,
    input  byte_cnt
`ifdef STATE_PARITY_EN
   ,output in_par,
    input  out_par_err
`endif
  );

  modport slave (
    input  clr,
    input  in_byte,
    input  in_valid,
    output in_ready,
    output out_state,
    output out_valid,
    input  out_ready,
    output byte_cnt
`ifdef STATE_PARITY_EN
   ,input  in_par,
    output out_par_err
`endif
  );
endinterface

// File: rtl/state_byte_assembler.sv
// Double-buffered byte-serial to 128-bit flat AES state assembler.
// Optional STATE_PARITY_EN: per-byte even-parity check, sticky per block.
module state_byte_assembler #(
  parameter int NUM_BYTES = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic clk,
  input logic rst,
  state_byte_assembler_if.slave bus
);
  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  typedef enum logic {FILL, STALL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  asm_q, asm_d;
  logic [W-1:0]  out_q, out_d;
  logic          ovld_q, ovld_d;

  logic          rdy;
  logic          acc;
  logic          xfer;
  logic          last;
  logic [CW-1:0] slot;
  logic [W-1:0]  asm_wr;

`ifdef STATE_PARITY_EN
  logic blk_err_q, blk_err_d;
  logic out_err_q, out_err_d;
  logic blk_err_new;
`endif

  assign rdy  = (state_q == FILL);
  assign acc  = bus.in_valid && rdy;
  assign xfer = ovld_q && bus.out_ready;
  assign last = (cnt_q == LAST);
  assign slot = MSB_FIRST ? (LAST - cnt_q) : cnt_q;

  always_comb begin
    asm_wr = asm_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (slot == CW'(i)) asm_wr[8*i +: 8] = bus.in_byte;
    end
  end

`ifdef STATE_PARITY_EN
  // A block's sticky bit restarts with its first byte.
  assign blk_err_new = ((cnt_q == '0) ? 1'b0 : blk_err_q)
                     | (^{bus.in_byte, bus.in_par});
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    out_d   = out_q;
    ovld_d  = ovld_q;
`ifdef STATE_PARITY_EN
    blk_err_d = blk_err_q;
    out_err_d = out_err_q;
`endif
    if (bus.clr) begin
      state_d = FILL;
      cnt_d   = '0;
      asm_d   = '0;
      ovld_d  = 1'b0;
`ifdef STATE_PARITY_EN
      blk_err_d = 1'b0;
      out_err_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        FILL: begin
          if (xfer) ovld_d = 1'b0;
          if (acc) begin
            asm_d = asm_wr;
`ifdef STATE_PARITY_EN
            blk_err_d = blk_err_new;
`endif
            if (last) begin
              cnt_d = '0;
              if (!ovld_q || bus.out_ready) begin
                out_d  = asm_wr;
                ovld_d = 1'b1;
`ifdef STATE_PARITY_EN
                out_err_d = blk_err_new;
`endif
              end else begin
                state_d = STALL;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        STALL: begin
          // Completed block waits in the assembly register.
          if (xfer) begin
            out_d   = asm_q;
            ovld_d  = 1'b1;
            state_d = FILL;
`ifdef STATE_PARITY_EN
            out_err_d = blk_err_q;
            blk_err_d = 1'b0;
`endif
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      ovld_q  <= 1'b0;
`ifdef STATE_PARITY_EN
      blk_err_q <= 1'b0;
      out_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      ovld_q  <= ovld_d;
`ifdef STATE_PARITY_EN
      blk_err_q <= blk_err_d;
      out_err_q <= out_err_d;
`endif
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_state = out_q;
  assign bus.out_valid = ovld_q;
  assign bus.byte_cnt  = cnt_q;
`ifdef STATE_PARITY_EN
  assign bus.out_par_err = ovld_q & out_err_q;
`endif
endmodule

// File: tb/tb_state_byte_assembler.sv
// Directed bench: LSB-first and MSB-first assemblers driven in lockstep.
// Parity steps are built only with STATE_PARITY_EN.
module tb_state_byte_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  state_byte_assembler_if #(.NUM_BYTES(16)) la ();
  state_byte_assembler_if #(.NUM_BYTES(16)) ma ();

  assign ma.clr       = la.clr;
  assign ma.in_byte   = la.in_byte;
  assign ma.in_valid  = la.in_valid;
  assign ma.out_ready = la.out_ready;
`ifdef STATE_PARITY_EN
  assign ma.in_par    = la.in_par;
`endif

  state_byte_assembler #(.NUM_BYTES(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(la.slave)
  );
  state_byte_assembler #(.NUM_BYTES(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bus(ma.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    la.in_byte  = b;
    la.in_valid = 1'b1;
`ifdef STATE_PARITY_EN
    la.in_par   = ^b;
`endif
    tick();
    la.in_valid = 1'b0;
  endtask

  initial begin
    la.clr       = 1'b0;
    la.in_byte   = 8'h00;
    la.in_valid  = 1'b0;
    la.out_ready = 1'b1;
`ifdef STATE_PARITY_EN
    la.in_par    = 1'b0;
`endif
    #2;
    chk("rst_ovld", 128'(la.out_valid), 128'd0);
    chk("rst_cnt", 128'(la.byte_cnt), 128'd0);
    chk("rst_state", la.out_state, 128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 128'(la.in_ready), 128'd1);

    // Block 00..0F with out_ready=1
    for (int k = 0; k < 15; k++) send(8'(k));
    chk("t1_cnt15", 128'(la.byte_cnt), 128'd15);
    chk("t1_ovld_pre", 128'(la.out_valid), 128'd0);
    send(8'h0F);
    chk("t1_ovld", 128'(la.out_valid), 128'd1);
    chk("t1_lsb", la.out_state,
        128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_msb", ma.out_state,
        128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_cnt0", 128'(la.byte_cnt), 128'd0);
    tick();
    chk("t1_ovld_drop", 128'(la.out_valid), 128'd0);

    // Back-pressure: A then B with out_ready=0
    la.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(8'(k));
    chk("t3_a_ovld", 128'(la.out_valid), 128'd1);
    chk("t3_a_rdy", 128'(la.in_ready), 128'd1);
    for (int k = 16; k < 32; k++) send(8'(k));
    chk("t3_stall_rdy", 128'(la.in_ready), 128'd0);
    chk("t3_hold_a", la.out_state,
        128'h0F0E0D0C0B0A09080706050403020100);
    tick();
    chk("t3_hold_a2", ma.out_state,
        128'h000102030405060708090A0B0C0D0E0F);
    chk("t3_stall_rdy2", 128'(ma.in_ready), 128'd0);
    la.out_ready = 1'b1;
    tick();
    la.out_ready = 1'b0;
    chk("t3_b_lsb", la.out_state,
        128'h1F1E1D1C1B1A19181716151413121110);
    chk("t3_b_msb", ma.out_state,
        128'h101112131415161718191A1B1C1D1E1F);
    chk("t3_b_ovld", 128'(la.out_valid), 128'd1);
    chk("t3_b_rdy", 128'(la.in_ready), 128'd1);
    la.out_ready = 1'b1;
    tick();
    chk("t3_drain", 128'(la.out_valid), 128'd0);

    // Partial block aborted by clr
    for (int k = 0; k < 7; k++) send(8'h55);
    chk("t4_cnt7", 128'(la.byte_cnt), 128'd7);
    la.clr      = 1'b1;
    la.in_byte  = 8'h77;
    la.in_valid = 1'b1;
    tick();
    la.clr      = 1'b0;
    la.in_valid = 1'b0;
    chk("t4_clr_cnt", 128'(la.byte_cnt), 128'd0);
    chk("t4_clr_ovld", 128'(la.out_valid), 128'd0);
    for (int k = 0; k < 16; k++) send(8'hA0 + 8'(k));
    chk("t4_lsb", la.out_state,
        128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    chk("t4_msb", ma.out_state,
        128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

    // clr also drops a held output
    la.out_ready = 1'b0;
    tick();
    chk("t4_held", 128'(la.out_valid), 128'd1);
    la.clr = 1'b1;
    tick();
    la.clr = 1'b0;
    chk("t4_clr_out", 128'(la.out_valid), 128'd0);

    // Async reset mid-block with a held output
    for (int k = 0; k < 16; k++) send(8'h30 + 8'(k));
    for (int k = 0; k < 9; k++) send(8'hC0);
    chk("t5_cnt9", 128'(la.byte_cnt), 128'd9);
    chk("t5_ovld", 128'(la.out_valid), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_ovld0", 128'(la.out_valid), 128'd0);
    chk("t5_cnt0", 128'(la.byte_cnt), 128'd0);
    chk("t5_state0", la.out_state, 128'd0);
    tick();
    rst = 1'b0;
    la.out_ready = 1'b1;
    tick();
    chk("t5_rdy", 128'(la.in_ready), 128'd1);

`ifdef STATE_PARITY_EN
    for (int k = 0; k < 16; k++) begin
      la.in_byte  = 8'h40 + 8'(k);
      la.in_valid = 1'b1;
      la.in_par   = (k == 5) ? ~^la.in_byte : ^la.in_byte;
      tick();
    end
    la.in_valid = 1'b0;
    chk("par_err1", 128'(la.out_par_err), 128'd1);
    chk("par_err1_m", 128'(ma.out_par_err), 128'd1);
    tick();
    chk("par_idle", 128'(la.out_par_err), 128'd0);
    for (int k = 0; k < 16; k++) send(8'h60 + 8'(k));
    chk("par_clean", 128'(la.out_par_err), 128'd0);
    chk("par_clean_v", 128'(la.out_valid), 128'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
